// File: rtl/multibyte_add_seq.sv
// Wide add/subtract sequencer: time-multiplexes one 8-bit adder over NBYTES
// byte slices, LSB first, with the carry chained through a register.
module multibyte_add_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic [NBYTES-1:0][7:0]  a_q;
  logic [NBYTES-1:0][7:0]  b_q;
  logic [NBYTES-1:0][7:0]  res_q;
  logic [8:0]              sum9;
  logic                    last;

  assign last   = (idx == LAST_IDX);
  assign result = res_q;

  // The single shared byte adder; bit 8 is the slice carry out.
  assign sum9 = {1'b0, a_q[idx]} + {1'b0, b_q[idx]} + {8'd0, carry};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last)  state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n != S_IDLE);
      done <= (state_n == S_DONE);
    end
  end

  // Operand capture, byte-serial accumulation and final flag update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            // Subtraction as A + ~B + 1: invert B here, inject the +1 as carry-in.
            b_q   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        S_RUN: begin
          res_q[idx] <= sum9[7:0];
          carry      <= sum9[8];
          if (last) begin
            cout <= sum9[8];
            ovf  <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &
                    (sum9[7] != a_q[NBYTES-1][7]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq against an arithmetic reference model.
module tb_multibyte_add_seq;

  parameter int unsigned NBYTES = 4;
  localparam int unsigned W = 8 * NBYTES;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  multibyte_add_seq #(.NBYTES(NBYTES)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: plain W-bit arithmetic, unsigned carry/borrow and signed range.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]        u;
    logic signed [W:0] sx;
    logic signed [W:0] sy;
    logic signed [W:0] ss;
    if (s) begin
      r = x - y;
      c = (x >= y);
    end else begin
      u = {1'b0, x} + {1'b0, y};
      r = u[W-1:0];
      c = u[W];
    end
    sx = {x[W-1], x};
    sy = {y[W-1], y};
    ss = s ? (sx - sy) : (sx + sy);
    v  = (ss[W] != ss[W-1]);
  endtask

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return W'(t);
  endfunction

  // Single operation from IDLE; returns in IDLE, #1 after an edge.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                       input string tag);
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    int           n;
    model(oa, ob, os, er, ec, ev);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = rnd(); b = rnd(); sub = ~os;
    chk({tag, "_busy"}, 64'(busy), 64'(1));
    n = 0;
    while (!done && n < int'(NBYTES) + 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(NBYTES));
    chk({tag, "_res"}, 64'(result), 64'(er));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(ev));
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, 64'(done), 64'(0));
    chk({tag, "_busy_clr"}, 64'(busy), 64'(0));
  endtask

  initial begin
    logic [W-1:0] er;
    logic         ec;
    logic         ev;
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];
    logic         qs [3];
    int           n;
    int           ndone;
    int           t_prev;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_res", 64'(result), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Boundary carries, borrows and signed overflow.
    do_op(W'(32'hFFFF_FFFF), W'(32'h0000_0001), 1'b0, "add_wrap");
    do_op(W'(32'h0000_0005), W'(32'h0000_0007), 1'b1, "sub_borrow");
    do_op(W'(32'h7FFF_FFFF), W'(32'h0000_0001), 1'b0, "add_ovf");
    do_op(W'(32'h8000_0000), W'(32'h0000_0001), 1'b1, "sub_ovf");

    // Start pulses during RUN and DONE must be ignored.
    model(W'(32'h0102_0304), W'(32'h1010_1010), 1'b0, er, ec, ev);
    a = W'(32'h0102_0304); b = W'(32'h1010_1010); sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int i = 0; i < int'(NBYTES) + 1; i++) begin
      a = rnd(); b = rnd(); sub = $urandom_range(0, 1) == 1; start = 1'b1;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        chk("ign_res_at_done", 64'(result), 64'(er));
      end
    end
    start = 1'b0;
    chk("ign_ndone", 64'(ndone), 64'(1));
    chk("ign_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ign_res_hold", 64'(result), 64'(er));
    chk("ign_idle", 64'(busy), 64'(0));

    // Asynchronous reset in the second RUN cycle, after a flag-setting op.
    do_op(W'(32'h8000_0000), W'(32'h0000_0001), 1'b1, "pre_rst");
    a = W'(32'hAAAA_AAAA); b = W'(32'h5555_5555); sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_res", 64'(result), 64'(0));
    chk("arst_cout", 64'(cout), 64'(0));
    chk("arst_ovf", 64'(ovf), 64'(0));
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", 64'(busy), 64'(0));
    do_op(W'(32'h1234_5678), W'(32'h1111_1111), 1'b0, "post_rst");

    // Start held high: three back-to-back random ops, spacing NBYTES+2.
    for (int k = 0; k < 3; k++) begin
      qa[k] = rnd(); qb[k] = rnd(); qs[k] = $urandom_range(0, 1) == 1;
    end
    a = qa[0]; b = qb[0]; sub = qs[0]; start = 1'b1;
    @(posedge clk); #1;
    a = rnd(); b = rnd(); sub = ~qs[0];
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      model(qa[k], qb[k], qs[k], er, ec, ev);
      n = 0;
      while (!done && n < 2 * int'(NBYTES) + 8) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_done_seen", 64'(done), 64'(1));
      chk("b2b_lat", 64'(n), 64'(NBYTES));
      chk("b2b_res", 64'(result), 64'(er));
      chk("b2b_cout", 64'(cout), 64'(ec));
      chk("b2b_ovf", 64'(ovf), 64'(ev));
      if (k > 0) chk("b2b_space", 64'(cyc - t_prev), 64'(NBYTES + 2));
      t_prev = cyc;
      if (k < 2) begin
        a = qa[k+1]; b = qb[k+1]; sub = qs[k+1];
        @(posedge clk); #1;
        chk("b2b_gap_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        chk("b2b_accept", 64'(busy), 64'(1));
        a = rnd(); b = rnd(); sub = ~qs[k+1];
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // Random single operations.
    for (int i = 0; i < 24; i++) begin
      do_op(rnd(), rnd(), $urandom_range(0, 1) == 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
